rv32m_muldiv_unit: RTL and testbench



---
 rtl/rv32m_muldiv_unit.sv | 131 +++++++++++++
 tb/tb_rv32m_muldiv_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide
// on operand magnitudes, sign fixup on the last step, one-cycle DONE write-back.
module rv32m_muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [2:0]   funct3_i,
  input  logic [N-1:0] rs1_data_i,
  input  logic [N-1:0] rs2_data_i,
  input  logic [4:0]   rd_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] result_o,
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [2:0]     f3;
  logic           sa, sb;
  logic [N-1:0]   a_mag, b_mag;
  logic [2*N-1:0] acc;
  logic [5:0]     cnt;

  // Operand decode at the start edge
  logic         is_div_in, a_signed_in, b_signed_in, sa_in, sb_in;
  logic         div_zero, div_ovf, special;
  logic [N-1:0] a_mag_in, b_mag_in, special_res;

  assign is_div_in   = funct3_i[2];
  assign a_signed_in = !(funct3_i[0] && (funct3_i[1] || funct3_i[2]));
  assign b_signed_in = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
  assign sa_in       = a_signed_in && rs1_data_i[N-1];
  assign sb_in       = b_signed_in && rs2_data_i[N-1];
  assign a_mag_in    = sa_in ? -rs1_data_i : rs1_data_i;
  assign b_mag_in    = sb_in ? -rs2_data_i : rs2_data_i;
  assign div_zero    = is_div_in && (rs2_data_i == '0);
  assign div_ovf     = is_div_in && b_signed_in && (rs1_data_i == {1'b1, {(N-1){1'b0}}})
                       && (rs2_data_i == '1);
  assign special     = div_zero || div_ovf;
  // Overflow dividend is the most negative value, which is also the DIV result
  assign special_res = funct3_i[1] ? (div_zero ? rs1_data_i : '0)
                                   : (div_zero ? '1 : rs1_data_i);

  // One iteration step; multiply keeps {hi, multiplier}, divide keeps {rem, quotient}
  logic [N:0]     mul_sum, div_shl;
  logic           div_ge;
  logic [N-1:0]   div_sub;
  logic [2*N-1:0] acc_next, prod_f;
  logic [N-1:0]   quo_f, rem_f, final_res;

  assign mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? a_mag : '0)};
  assign div_shl  = {acc[2*N-1:N], acc[N-1]};
  assign div_ge   = div_shl >= {1'b0, b_mag};
  assign div_sub  = div_shl[N-1:0] - b_mag;
  assign acc_next = f3[2] ? (div_ge ? {div_sub, acc[N-2:0], 1'b1} : {acc[2*N-2:0], 1'b0})
                          : {mul_sum, acc[N-1:1]};
  assign prod_f   = (sa ^ sb) ? -acc_next : acc_next;
  assign quo_f    = (sa ^ sb) ? -acc_next[N-1:0] : acc_next[N-1:0];
  assign rem_f    = sa ? -acc_next[2*N-1:N] : acc_next[2*N-1:N];

  always_comb begin
    final_res = prod_f[2*N-1:N];
    case (f3)
      3'b000:         final_res = prod_f[N-1:0];
      3'b100, 3'b101: final_res = quo_f;
      3'b110, 3'b111: final_res = rem_f;
      default:        final_res = prod_f[2*N-1:N];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = special ? DONE : CALC;
      CALC:    if (cnt == 6'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = ((state == IDLE) && start_i) || (state == CALC);
    done_o      = (state == DONE);
    Reg_Write_o = (state == DONE) && (Write_Register_o != 5'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3               <= '0;
      sa               <= 1'b0;
      sb               <= 1'b0;
      a_mag            <= '0;
      b_mag            <= '0;
      acc              <= '0;
      cnt              <= '0;
      result_o         <= '0;
      Write_Register_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          f3               <= funct3_i;
          sa               <= sa_in;
          sb               <= sb_in;
          a_mag            <= a_mag_in;
          b_mag            <= b_mag_in;
          acc              <= {{N{1'b0}}, (is_div_in ? a_mag_in : b_mag_in)};
          cnt              <= 6'd32;
          Write_Register_o <= rd_i;
          if (special) result_o <= special_res;
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) result_o <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Self-checking bench for rv32m_muldiv_unit: directed plan cases plus random operations
// compared against a 64-bit arithmetic reference model.
module tb_rv32m_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_i;
  logic        busy_o, done_o, Reg_Write_o;
  logic [31:0] result_o;
  logic [4:0]  Write_Register_o;

  int checks = 0;
  int errors = 0;

  rv32m_muldiv_unit #(.N(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .Reg_Write_o(Reg_Write_o), .Write_Register_o(Write_Register_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (f3)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
      end
    endcase
    return p[31:0];
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold);
    logic [31:0] exp;
    bit spec, got_done;
    int edges, busy_n;
    exp  = ref_model(f3, a, b);
    spec = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    @(negedge clk);
    start_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_i = rd;
    #1;
    busy_n   = busy_o ? 1 : 0;
    edges    = 0;
    got_done = 1'b0;
    while (!got_done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (done_o) got_done = 1'b1;
      else begin
        if (busy_o) busy_n++;
        if (!hold) begin
          start_i    = 1'b0;
          funct3_i   = 3'($urandom);
          rs1_data_i = $urandom;
          rs2_data_i = $urandom;
          rd_i       = 5'($urandom);
        end
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("latency", 32'(edges), spec ? 32'd1 : 32'd33);
    chk("busy_cycles", 32'(busy_n), spec ? 32'd1 : 32'd33);
    chk("result", result_o, exp);
    chk("wr_reg", 32'(Write_Register_o), 32'(rd));
    chk("reg_write", 32'(Reg_Write_o), 32'(rd != 5'd0));
    chk("busy_in_done", 32'(busy_o), 32'd0);
    if (!hold) start_i = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", 32'(done_o), 32'd0);
    chk("reg_write_idle", 32'(Reg_Write_o), 32'd0);
    chk("result_hold", result_o, exp);
    if (hold) begin
      chk("busy_idle_start", 32'(busy_o), 32'd1);
      start_i = 1'b0;
      #1;
      chk("single_op", 32'(busy_o), 32'd0);
      repeat (3) begin
        @(posedge clk); #1;
        chk("no_rerun", 32'({busy_o, done_o}), 32'd0);
      end
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    reset = 1'b1; start_i = 1'b1; funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0; rd_i = '0;
    #1;
    chk("rst_busy_follows_start", 32'(busy_o), 32'd1);
    start_i = 1'b0;
    #1;
    chk("rst_busy_low", 32'(busy_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_reg_write", 32'(Reg_Write_o), 32'd0);
    chk("rst_wr_reg", 32'(Write_Register_o), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Directed cases with fixed expectations
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 1'b0);
    chk("mul_7x-3", result_o, 32'hFFFF_FFEB);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
    chk("mulh_m1", result_o, 32'h0000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    chk("mulhu_m1", result_o, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    chk("mulhsu_m1", result_o, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    chk("div_-7_2", result_o, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    chk("rem_-7_2", result_o, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b0);
    chk("divu_100_7", result_o, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b0);
    chk("remu_100_7", result_o, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, 5'd9, 1'b0);
    chk("div_by_zero", result_o, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, 5'd10, 1'b0);
    chk("remu_by_zero", result_o, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
    chk("div_ovf", result_o, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    chk("rem_ovf", result_o, 32'h0);
    run_op(3'd0, 32'd6, 32'd9, 5'd0, 1'b0);
    run_op(3'd0, 32'd6, 32'd9, 5'd13, 1'b1);
    run_op(3'd6, 32'd5, 32'd0, 5'd14, 1'b1);

    // Reset in the middle of a calculation
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd0; rs1_data_i = 32'd7; rs2_data_i = 32'hFFFF_FFFD; rd_i = 5'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_wr_reg", 32'(Write_Register_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_reg_write", 32'(Reg_Write_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    @(negedge clk); reset = 1'b0;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    chk("post_rst_mul", result_o, 32'hFFFF_FFEB);

    // Random operations, biased towards the divide corner cases
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(f3, a, b, rd, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
